pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges stall requests from the IF, ID, EX and MEM stages into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also sequences exception/ERET flushes through a two-cycle freeze-then-flush FSM, supplies the redirect PC, and keeps stall statistics plus a stall watchdog.

Parameters:
EXC_VECTOR, 32'h00000020, PC loaded on flush for every exception except ERET
CNT_W, 32, width of the stall-cycle statistics counter
WDOG_LIMIT, 1024, consecutive stalled cycles that trip stall_timeout

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
stallreq_if  in  1  instruction-bus wait
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (madd/msub/div) in progress
stallreq_mem  in  1  data-bus wait
excepttype_i  in  32  exception code from the MEM stage; 0 means none
cp0_epc_i  in  32  current EPC from CP0
clr_stats  in  1  clears stall_cycles and stall_timeout
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
flush  out  1  registered one-cycle pipeline flush
new_pc  out  32  redirect target; valid only while flush=1
stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
Reset, rst=1 at a clock edge:
- state=IDLE, flush=0, new_pc=0, stall_cycles=0, stall_timeout=0, run counter=0.
- stall output forced to 6'b000000 while rst=1.
- Reset asserted mid-FREEZE or mid-FLUSH aborts the sequence; no flush pulse follows.

Stall vector, combinational from the request inputs in IDLE. Priority order, highest first:
- stallreq_mem -> 6'b011111
- else stallreq_ex -> 6'b001111
- else stallreq_id -> 6'b000111
- else stallreq_if -> 6'b000111
- else 6'b000000
Simultaneous requests: the highest-priority request wins and its vector is output unmodified (no OR-ing).

Exception FSM, states IDLE, FREEZE, FLUSH:
- IDLE -> FREEZE when excepttype_i!=0 and stallreq_mem=0.
  - If stallreq_mem=1, the exception is deferred. The MEM stage is frozen, so the code remains presented.
- At the IDLE->FREEZE edge, new_pc is latched:
  - excepttype_i==32'h0000000e (ERET) -> cp0_epc_i
  - any other nonzero code -> EXC_VECTOR
- FREEZE: stall=6'b111111 for exactly one cycle; flush=0; all request inputs ignored.
- FREEZE -> FLUSH unconditionally.
- FLUSH: flush=1, stall=6'b000000, new_pc held. Request inputs and excepttype_i are ignored.
- FLUSH -> IDLE unconditionally.
- flush=0 in all states except FLUSH. new_pc holds its last value outside FLUSH.
- Latency: an exception accepted at edge N gives flush=1 in the cycle after edge N+1, for exactly one cycle.
- Back-to-back exceptions: a code still present on the first IDLE cycle after FLUSH starts a new sequence.

Statistics:
- stall_cycles increments on each edge where stall[0]=1 (this includes FREEZE).
- stall_cycles saturates at all-ones and never wraps.
- run counter increments while stall[0]=1 and resets to 0 on any cycle with stall[0]=0.
  - It is internal and saturates at WDOG_LIMIT.
- stall_timeout sets when the run counter reaches WDOG_LIMIT. It stays set until rst or clr_stats.
- clr_stats=1 zeroes stall_cycles, the run counter and stall_timeout at that edge. clr_stats has priority over a simultaneous increment or set.

Test Plan:
- Priority: stallreq_if=1, stallreq_id=1, stallreq_ex=1, stallreq_mem=1 together -> stall=6'b011111. Drop mem -> 6'b001111. Drop ex -> 6'b000111. All low -> 6'b000000.
- Syscall: excepttype_i=32'h00000008 for one cycle -> next cycle stall=6'b111111, following cycle flush=1 with new_pc=32'h00000020, then flush=0 and state IDLE.
- ERET: cp0_epc_i=32'h80001234, excepttype_i=32'h0000000e -> flush pulse with new_pc=32'h80001234.
- Deferral: excepttype_i=32'h0000000c held with stallreq_mem=1 for 3 cycles -> stall=6'b011111 and no FREEZE for those 3 cycles. FREEZE begins on the edge where stallreq_mem drops; flush follows one cycle later.
- Watchdog/stats: with WDOG_LIMIT=8, hold stallreq_ex=1 for 8 cycles -> stall_timeout=1 and stall_cycles=8. Pulse clr_stats with stallreq_ex still high -> stall_cycles=0 and stall_timeout=0 at that edge.
- Reset mid-sequence: assert rst in the FREEZE cycle -> next cycle flush=0, stall=0, state IDLE, and no flush pulse ever appears.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests into the stall vector, runs the
// exception freeze/flush sequence, supplies the redirect PC, and tracks stall statistics.
module pipeline_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int          CNT_W      = 32,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             clr_stats,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam int               RUN_W     = $clog2(WDOG_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(WDOG_LIMIT);
  localparam logic [31:0]      ERET_CODE = 32'h0000000e;

  typedef enum logic [1:0] {IDLE, FREEZE, FLUSH} state_t;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic ifs;
  } stall_req_t;

  state_t           state, state_nxt;
  stall_req_t       req;
  logic [5:0]       req_stall;
  logic             accept;
  logic [RUN_W-1:0] run, run_nxt;

  assign req = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id, ifs: stallreq_if};

  // Strict priority: the winning stage's vector is used as-is, never OR-ed.
  always_comb begin
    req_stall = 6'b000000;
    if (req.mem)                 req_stall = 6'b011111;
    else if (req.ex)             req_stall = 6'b001111;
    else if (req.id || req.ifs)  req_stall = 6'b000111;
  end

  always_comb begin
    state_nxt = state;
    stall     = 6'b000000;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        stall = req_stall;
        // A data-bus wait freezes MEM, so the exception code stays presented until it drops.
        if (excepttype_i != 32'd0 && !req.mem) begin
          state_nxt = FREEZE;
          accept    = 1'b1;
        end
      end
      FREEZE: begin
        stall     = 6'b111111;
        state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) stall = 6'b000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      flush  <= 1'b0;
      new_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      flush <= (state == FREEZE);
      if (accept)
        new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  always_comb begin
    run_nxt = '0;
    if (stall[0]) run_nxt = (run == RUN_MAX) ? run : run + RUN_W'(1);
  end

  // clr_stats outranks any increment or watchdog set on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stall_cycles  <= '0;
      run           <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run <= run_nxt;
      if (stall[0] && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (run_nxt == RUN_MAX)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table-driven cycle vectors fed through a
// scoreboard queue, plus hand-built watchdog/statistics and reset-abort sequences.
module tb_pipeline_stall_ctrl;

  logic        clk, rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, clr_stats;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles;
  logic        stall_timeout;

  pipeline_stall_ctrl #(.EXC_VECTOR(32'h00000020), .CNT_W(4), .WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .clr_stats(clr_stats),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  req;    // {mem, ex, id, if}
    logic        clr;
    logic [31:0] exc, epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        chk_st;
    logic [3:0]  e_cnt;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0, bad = 0, cyc_n = 0;

  localparam logic [3:0] NONE = 4'b0000, RIF = 4'b0001, RID = 4'b0010,
                         REX = 4'b0100, RMEM = 4'b1000;
  localparam logic [31:0] SYS = 32'h8, ERET = 32'he, OVF = 32'hc, VEC = 32'h20,
                          EPC = 32'h80001234;

  function automatic vec_t mk(logic r, logic [3:0] req, logic clr, logic [31:0] exc,
                              logic [31:0] epc, logic [5:0] es, logic ef, logic cp,
                              logic [31:0] ep, logic cs, logic [3:0] ec, logic et);
    vec_t v;
    v.r = r; v.req = req; v.clr = clr; v.exc = exc; v.epc = epc;
    v.e_stall = es; v.e_flush = ef; v.chk_pc = cp; v.e_pc = ep;
    v.chk_st = cs; v.e_cnt = ec; v.e_to = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the edge, queue its expectation, check at the negedge.
  task automatic cyc(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    rst = v.r; clr_stats = v.clr;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = v.req;
    excepttype_i = v.exc; cp0_epc_i = v.epc;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("stall", 32'(stall), 32'(e.e_stall));
    chk("flush", 32'(flush), 32'(e.e_flush));
    if (e.chk_pc) chk("new_pc", new_pc, e.e_pc);
    if (e.chk_st) begin
      chk("stall_cycles", 32'(stall_cycles), 32'(e.e_cnt));
      chk("stall_timeout", 32'(stall_timeout), 32'(e.e_to));
    end
    cyc_n++;
  endtask

  initial begin
    rst = 1'b1; clr_stats = 1'b0; excepttype_i = '0; cp0_epc_i = '0;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = '0;

    // reset: requests present but stall forced low
    tbl.push_back(mk(1, 4'b1111, 0, 0,    0,   6'b000000, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, RMEM,    0, SYS,  0,   6'b000000, 0, 1, 0, 1, 0, 0));
    // priority
    tbl.push_back(mk(0, 4'b1111, 0, 0,    0,   6'b011111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0111, 0, 0,    0,   6'b001111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 0,    0,   6'b000111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RIF,     0, 0,    0,   6'b000111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RID,     0, 0,    0,   6'b000111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 0, 0, 0, 0, 0, 0));
    // syscall: requests ignored in FREEZE and FLUSH
    tbl.push_back(mk(0, NONE,    0, SYS,  0,   6'b000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RMEM,    0, 0,    0,   6'b111111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RMEM,    0, 0,    0,   6'b000000, 1, 1, VEC, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 0, 0, 0, 0, 0, 0));
    // ERET: EPC latched at acceptance, later EPC changes do not matter
    tbl.push_back(mk(0, NONE,    0, ERET, EPC, 6'b000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    32'h1111, 6'b111111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, REX,     0, 0,    32'h2222, 6'b000000, 1, 1, EPC, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 0, 1, EPC, 0, 0, 0));
    // deferral behind a data-bus wait
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, RMEM,  0, OVF,  0,   6'b011111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, OVF,  0,   6'b000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b111111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 1, 1, VEC, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 0, 0, 0, 0, 0, 0));
    // back-to-back: code held through FREEZE/FLUSH restarts in the next IDLE cycle
    tbl.push_back(mk(0, NONE,    0, ERET, 32'h44, 6'b000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, SYS,  0,   6'b111111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, SYS,  0,   6'b000000, 1, 1, 32'h44, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, SYS,  0,   6'b000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b111111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 1, 1, VEC, 0, 0, 0));
    tbl.push_back(mk(0, NONE,    0, 0,    0,   6'b000000, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) cyc(tbl[i]);

    // watchdog: timeout exactly when the 8th consecutive stall edge lands
    cyc(mk(0, NONE, 1, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= 8; i++)
      cyc(mk(0, REX, 0, 0, 0, 6'b001111, 0, 0, 0, 1, 4'(i), (i == 8)));
    // clr_stats wins over a simultaneous increment
    cyc(mk(0, REX, 1, 0, 0, 6'b001111, 0, 0, 0, 1, 4'd9, 1));
    cyc(mk(0, REX, 0, 0, 0, 6'b001111, 0, 0, 0, 1, 4'd0, 0));
    // saturation of the 4-bit counter, then sticky timeout after stalls stop
    for (int i = 1; i <= 20; i++)
      cyc(mk(0, REX, 0, 0, 0, 6'b001111, 0, 0, 0, 1, (i > 15) ? 4'd15 : 4'(i), (i >= 8)));
    cyc(mk(0, NONE, 0, 0, 0, 6'b000000, 0, 0, 0, 1, 4'd15, 1));
    cyc(mk(0, NONE, 0, 0, 0, 6'b000000, 0, 0, 0, 1, 4'd15, 1));
    // an idle cycle restarts the run, so two 5-cycle bursts never trip
    cyc(mk(0, NONE, 1, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      cyc(mk(0, REX, 0, 0, 0, 6'b001111, 0, 0, 0, 1, 4'(i), 0));
    cyc(mk(0, NONE, 0, 0, 0, 6'b000000, 0, 0, 0, 1, 4'd5, 0));
    for (int i = 0; i < 5; i++)
      cyc(mk(0, RIF, 0, 0, 0, 6'b000111, 0, 0, 0, 1, 4'(5 + i), 0));
    cyc(mk(0, NONE, 0, 0, 0, 6'b000000, 0, 0, 0, 1, 4'd10, 0));

    // reset during FREEZE aborts the sequence; IDLE proven by stallreq_if being honoured
    cyc(mk(0, NONE, 0, SYS, 0, 6'b000000, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, RMEM, 0, 0,   0, 6'b000000, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, RIF,  0, 0,   0, 6'b000111, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      cyc(mk(0, NONE, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
